instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Instruction fetch stage for the BIP processor. Owns the program counter, drives the address port of the program memory, tracks that memory's fixed read latency, and buffers returned instruction words in a small skid FIFO. The buffered words go to the decoder through a valid/stall handshake. Also handles jump redirects with flush, and detects the halt opcode.

## Interface
- `ADDR_WIDTH`, 11: program memory address width; PC width.
- `INST_WIDTH`, 16: instruction width; opcode is bits `[INST_WIDTH-1 -: 5]`.
- `MEM_LATENCY`, 2: cycles from address presented to data valid on `i_mem_data` (1 = low-latency memory, 2 = high-performance memory).
- `HALT_OPCODE`, 5'b00000: opcode that stops fetch.
- `i_clk`  in  1: clock; all state updates on rising edge.
- `i_rst`  in  1: reset; asynchronous, active-high.
- `i_enable`  in  1: fetch permitted while high.
- `i_stall`  in  1: decoder cannot accept the current instruction.
- `i_redirect`  in  1: jump request; single-cycle pulse.
- `i_redirect_addr`  in  ADDR_WIDTH: jump target.
- `o_mem_addr`  out  ADDR_WIDTH: program memory address; equals PC register.
- `i_mem_data`  in  INST_WIDTH: program memory read data.
- `o_inst`  out  INST_WIDTH: FIFO head instruction.
- `o_inst_pc`  out  ADDR_WIDTH: address of `o_inst`.
- `o_inst_valid`  out  1: `o_inst`/`o_inst_pc` valid.
- `o_halted`  out  1: halt opcode consumed; fetch stopped.

## Operation
- **Issue rule.** An issue occurs in a cycle when all of the following hold: `i_enable`, `!o_halted`, `!i_redirect`, no halt consumed this cycle, and `fifo_count + inflight < FIFO_DEPTH`.
  - `FIFO_DEPTH = MEM_LATENCY + 2`.
  - The occupancy check is conservative: a same-cycle pop is not counted.
  - On issue: PC increments at the edge, and a tag {valid=1, pc} enters a MEM_LATENCY-deep tag shift register.
- **Tag register.** The tag register shifts every cycle. The tag emerging at stage MEM_LATENCY marks `i_mem_data` as valid, and that word is pushed into the FIFO with its pc.
  - `inflight` is the number of valid tags in the register.
- **Output handshake.**
  - `o_inst_valid = (fifo_count != 0)`.
  - Pop when `o_inst_valid && !i_stall`.
  - While stalled, `o_inst`/`o_inst_pc` are held stable.
  - The FIFO never overflows; the issue rule guarantees this.
- **Redirect** (cycle N):
  - All tags are invalidated and the FIFO is emptied at edge N.
  - PC <= `i_redirect_addr`.
  - No instruction fetched before the redirect is ever delivered.
- **Halt.** When the popped instruction's opcode equals `HALT_OPCODE`:
  - The halt instruction itself is delivered once.
  - At that edge `o_halted` <= 1, the FIFO and tags are flushed, and PC is frozen.
  - Halt is sticky until reset.
  - Halt consumed in the same cycle as `i_redirect`: halt wins, redirect ignored.
- **PC arithmetic.** PC is modulo 2^ADDR_WIDTH; 2^ADDR_WIDTH-1 wraps to 0.
- **`i_enable` low.** No new issue; in-flight reads still land in the FIFO.

## Timing
- Reset values (asynchronous, immediate):
  - PC = 0, `o_mem_addr` = 0.
  - Tags clear, FIFO empty, FIFO storage 0.
  - `o_inst` = 0, `o_inst_pc` = 0, `o_inst_valid` = 0, `o_halted` = 0.
- **Reset mid-operation:** all in-flight reads are discarded.
- **Latency:** address issued in cycle C → `i_mem_data` sampled end of C+MEM_LATENCY → `o_inst_valid` in cycle C+MEM_LATENCY+1.
  - With MEM_LATENCY=2, the first valid after reset+enable is in the 4th cycle of enable.
- **Redirect in cycle N:** `o_mem_addr` = target in N+1; target instruction valid in N+MEM_LATENCY+2.
- **Throughput:** one instruction per cycle with no stall.

## Configuration
- `FETCH_HALT_DETECT_EN` defined: halt detection as above.
- Undefined: no opcode comparison; `o_halted` tied 0; fetch runs indefinitely and `HALT_OPCODE` is unused.

## Test plan
All scenarios use MEM_LATENCY=2, with program memory word k = 16'h0800 + k.
- Reset, then `i_enable`=1 and no stall → first `o_inst_valid` in cycle 4 with `o_inst`=16'h0800 and `o_inst_pc`=0; then one word per cycle, pc 1, 2, 3, … with no gaps.
- `i_stall`=1 for 5 cycles mid-stream → `o_inst` held; `o_mem_addr` stops once count+inflight=4. After release, pcs continue contiguously with no loss or duplicate.
- `i_redirect` to 0x100 while the FIFO holds 2 words and 2 reads are in flight → no stale word is delivered; next valid word is `o_inst_pc`=0x100 exactly 4 cycles after the redirect cycle.
- Word at address 5 has opcode `HALT_OPCODE` (macro defined) → pc 5 is delivered once; `o_halted`=1 in the next cycle; `o_inst_valid` stays 0 and `o_mem_addr` is frozen. A later `i_redirect` has no effect.
- Redirect to 0x7FE → delivered pcs are 0x7FE, 0x7FF, 0x000, 0x001.
- Assert `i_rst` between clock edges mid-stream → all outputs go to 0 before the next edge; fetch restarts from pc 0 after release.

Source files
------------

// File: rtl/instruction_fetch.sv
// instruction_fetch: BIP fetch stage. Owns the PC, drives program-memory
// addresses, tracks the memory's fixed read latency with a tag shift
// register, and buffers returned words in a skid FIFO toward the decoder.
// Optional halt-opcode detection is compiled in with FETCH_HALT_DETECT_EN;
// without it o_halted is tied low and fetch never stops on its own.
module instruction_fetch #(
  parameter int ADDR_WIDTH  = 11,
  parameter int INST_WIDTH  = 16,
  parameter int MEM_LATENCY = 2
`ifdef FETCH_HALT_DETECT_EN
  ,
  parameter logic [4:0] HALT_OPCODE = 5'b00000
`endif
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_stall,
  input  logic                  i_redirect,
  input  logic [ADDR_WIDTH-1:0] i_redirect_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [INST_WIDTH-1:0] i_mem_data,
  output logic [INST_WIDTH-1:0] o_inst,
  output logic [ADDR_WIDTH-1:0] o_inst_pc,
  output logic                  o_inst_valid,
  output logic                  o_halted
);

  // FIFO must absorb every read in flight plus the skid slots.
  localparam int FIFO_DEPTH = MEM_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_WIDTH-1:0]  pc;
  logic [MEM_LATENCY-1:0] tag_vld;
  logic [ADDR_WIDTH-1:0]  tag_pc [MEM_LATENCY];
  logic [INST_WIDTH-1:0]  fifo_inst [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc [FIFO_DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W:0]         occupancy;
  logic                   pop;
  logic                   push;
  logic                   halt_take;
  logic                   redirect_take;
  logic                   flush;
  logic                   issue;
  logic                   halted;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Count the reads still travelling through the memory pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      inflight = inflight + CNT_W'(tag_vld[i]);
    end
  end

  assign o_inst_valid = (count != '0);
  assign o_inst       = fifo_inst[rd_ptr];
  assign o_inst_pc    = fifo_pc[rd_ptr];
  assign o_mem_addr   = pc;
  assign o_halted     = halted;

  assign pop  = o_inst_valid && !i_stall;
  assign push = tag_vld[MEM_LATENCY-1];

`ifdef FETCH_HALT_DETECT_EN
  assign halt_take = pop && (o_inst[INST_WIDTH-1 -: 5] == HALT_OPCODE);
`else
  assign halt_take = 1'b0;
`endif

  // A halt popped in the same cycle as a redirect takes priority.
  assign redirect_take = i_redirect && !halted && !halt_take;
  assign flush         = redirect_take || halt_take;

  // Conservative occupancy: a same-cycle pop is not credited, so the FIFO
  // can never be overrun by reads already issued.
  assign occupancy = {1'b0, count} + {1'b0, inflight};
  assign issue     = i_enable && !halted && !i_redirect && !halt_take &&
                     (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  // Program counter: jump target on redirect, else advance per issue.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc <= '0;
    end else if (redirect_take) begin
      pc <= i_redirect_addr;
    end else if (issue) begin
      pc <= pc + ADDR_WIDTH'(1);
    end
  end

  // Tag valid pipeline: marks which memory-return cycles carry a live read.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tag_vld <= '0;
    end else if (flush) begin
      tag_vld <= '0;
    end else begin
      tag_vld[0] <= issue;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        tag_vld[i] <= tag_vld[i-1];
      end
    end
  end

  // Tag address pipeline: pc travels alongside its valid bit.
  always_ff @(posedge i_clk) begin
    tag_pc[0] <= pc;
    for (int i = 1; i < MEM_LATENCY; i++) begin
      tag_pc[i] <= tag_pc[i-1];
    end
  end

  // FIFO storage: capture the returning word with its address.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_inst[i] <= '0;
        fifo_pc[i]   <= '0;
      end
    end else if (push && !flush) begin
      fifo_inst[wr_ptr] <= i_mem_data;
      fifo_pc[wr_ptr]   <= tag_pc[MEM_LATENCY-1];
    end
  end

  // FIFO pointers and occupancy; a flush empties it in one edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_next(wr_ptr);
      if (pop)  rd_ptr <= ptr_next(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_HALT_DETECT_EN
  // Sticky halt flag, set when the halt instruction is consumed.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      halted <= 1'b0;
    end else if (halt_take) begin
      halted <= 1'b1;
    end
  end
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch (MEM_LATENCY=2). A queue-based transaction
// model predicts PC, FIFO contents and halt state; literal checks pin the
// start-up latency, stall, redirect, wrap, halt and async reset behaviour.
`timescale 1ns/1ps
module tb_instruction_fetch;
  localparam int AW    = 11;
  localparam int IW    = 16;
  localparam int ML    = 2;
  localparam int DEPTH = ML + 2;
`ifdef FETCH_HALT_DETECT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_enable, i_stall, i_redirect;
  logic [AW-1:0] i_redirect_addr;
  logic [AW-1:0] o_mem_addr, o_inst_pc;
  logic [IW-1:0] i_mem_data, o_inst;
  logic          o_inst_valid, o_halted;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int halt_at  = -1;
  int halt_cyc = -1;

  instruction_fetch #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .MEM_LATENCY(ML)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_stall(i_stall),
    .i_redirect(i_redirect), .i_redirect_addr(i_redirect_addr),
    .o_mem_addr(o_mem_addr), .i_mem_data(i_mem_data), .o_inst(o_inst),
    .o_inst_pc(o_inst_pc), .o_inst_valid(o_inst_valid), .o_halted(o_halted)
  );

  initial forever #5 i_clk = ~i_clk;

  // Program memory contents: word k = 0x0800 + k, optional halt word.
  function automatic logic [IW-1:0] mem_word(input int a);
    if (a == halt_at) return 16'h0005;
    return IW'(32'h0800 + a);
  endfunction

  // Program memory with fixed read latency ML.
  logic [AW-1:0] maddr [ML];
  always @(posedge i_clk) begin
    maddr[0] <= o_mem_addr;
    for (int i = 1; i < ML; i++) maddr[i] <= maddr[i-1];
  end
  assign i_mem_data = mem_word(int'(maddr[ML-1]));

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction model: reads in flight with landing cycle, FIFO of words.
  typedef struct { int land; int pc; } flight_t;
  typedef struct { int pc; int data; } entry_t;
  typedef struct { int cyc; int pc; int data; } dlv_t;
  flight_t fq[$];
  entry_t  mq[$];
  dlv_t    dlog[$];
  int      m_pc = 0;
  bit      m_halted = 1'b0;
  bit      m_pop, m_htake, m_rtake, m_iss;
  flight_t m_f;
  entry_t  m_e;

  always @(posedge i_clk) begin
    if (i_rst) begin
      fq.delete();
      mq.delete();
      m_pc = 0;
      m_halted = 1'b0;
    end else begin
      m_pop   = (mq.size() != 0) && !i_stall;
      m_htake = 1'b0;
      if (m_pop && HALT_EN) begin
        m_e = mq[0];
        m_htake = (((m_e.data >> 11) & 31) == 0);
      end
      m_rtake = i_redirect && !m_halted && !m_htake;
      m_iss   = i_enable && !m_halted && !i_redirect && !m_htake &&
                (mq.size() + fq.size() < DEPTH);
      if (m_pop) void'(mq.pop_front());
      if (fq.size() != 0 && fq[0].land == cyc) begin
        m_f = fq.pop_front();
        m_e.pc = m_f.pc;
        m_e.data = int'(mem_word(m_f.pc));
        mq.push_back(m_e);
      end
      if (m_htake || m_rtake) begin
        mq.delete();
        fq.delete();
      end
      if (m_htake) m_halted = 1'b1;
      if (m_rtake) begin
        m_pc = int'(i_redirect_addr);
      end else if (m_iss) begin
        m_f.land = cyc + ML;
        m_f.pc = m_pc;
        fq.push_back(m_f);
        m_pc = (m_pc + 1) % (1 << AW);
      end
    end
    cyc++;
  end

  // Per-cycle comparison against the model, plus delivery log.
  dlv_t d_tmp;
  always @(negedge i_clk) begin
    if (i_rst) begin
      chk("rst_valid", int'(o_inst_valid), 0);
      chk("rst_halted", int'(o_halted), 0);
      chk("rst_mem_addr", int'(o_mem_addr), 0);
    end else begin
      chk("mem_addr", int'(o_mem_addr), m_pc);
      chk("inst_valid", int'(o_inst_valid), int'(mq.size() != 0));
      chk("halted", int'(o_halted), int'(m_halted));
      if (mq.size() != 0) begin
        chk("inst_pc", int'(o_inst_pc), mq[0].pc);
        chk("inst", int'(o_inst), mq[0].data);
      end
      if (o_inst_valid && !i_stall) begin
        d_tmp.cyc = cyc;
        d_tmp.pc = int'(o_inst_pc);
        d_tmp.data = int'(o_inst);
        dlog.push_back(d_tmp);
      end
      if (o_halted && halt_cyc < 0) halt_cyc = cyc;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #2;
    end
  endtask

  function automatic int first_after(input int c);
    for (int i = 0; i < dlog.size(); i++) if (dlog[i].cyc > c) return i;
    return -1;
  endfunction

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_mem_addr"}, int'(o_mem_addr), 0);
    chk({tag, "_inst"}, int'(o_inst), 0);
    chk({tag, "_inst_pc"}, int'(o_inst_pc), 0);
    chk({tag, "_valid"}, int'(o_inst_valid), 0);
    chk({tag, "_halted"}, int'(o_halted), 0);
  endtask

  // Checks a run of pcs delivered back-to-back after cycle c.
  task automatic chk_seq(input string name, input int c, input int first_pc,
                         input int first_cyc, input int n);
    int idx;
    idx = first_after(c);
    if (idx < 0 || idx + n > dlog.size()) begin
      chk({name, "_deliveries_seen"}, 0, 1);
    end else begin
      chk({name, "_first_cycle"}, dlog[idx].cyc, first_cyc);
      for (int k = 0; k < n; k++) begin
        chk({name, "_pc"}, dlog[idx+k].pc, (first_pc + k) % (1 << AW));
        chk({name, "_data"}, dlog[idx+k].data, 32'h0800 + ((first_pc + k) % (1 << AW)));
        chk({name, "_cycle"}, dlog[idx+k].cyc, first_cyc + k);
      end
    end
  endtask

  int t0, t1, t2, t3, t4, t5, idx;

  initial begin
    i_enable = 1'b0; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_addr = '0;
    step(3);
    chk_reset_outputs("reset");
    i_rst = 1'b0;
    step(1);

    // Start-up: first valid in the 4th enabled cycle, then one per cycle.
    i_enable = 1'b1;
    t0 = cyc;
    step(14);
    chk_seq("startup", t0 - 1, 0, t0 + 3, 8);

    // Five-cycle stall: nothing delivered, stream resumes contiguously.
    i_stall = 1'b1;
    t1 = cyc;
    step(5);
    i_stall = 1'b0;
    step(8);
    idx = first_after(t1 - 1);
    if (idx < 0) chk("stall_resume_seen", 0, 1);
    else chk("stall_resume_cycle", dlog[idx].cyc, t1 + 5);
    idx = first_after(t0 - 1);
    for (int i = idx + 1; i < dlog.size(); i++)
      chk("stall_contiguous", dlog[i].pc, dlog[i-1].pc + 1);

    // Redirect with two buffered and two in-flight words.
    i_stall = 1'b1;
    step(1);
    i_stall = 1'b0;
    i_redirect = 1'b1;
    i_redirect_addr = 11'h100;
    t2 = cyc;
    step(1);
    i_redirect = 1'b0;
    step(8);
    chk_seq("redirect", t2, 32'h100, t2 + 4, 3);

    // Redirect near the top of the address space wraps to 0.
    i_redirect = 1'b1;
    i_redirect_addr = 11'h7FE;
    t3 = cyc;
    step(1);
    i_redirect = 1'b0;
    step(10);
    chk_seq("wrap", t3, 32'h7FE, t3 + 4, 4);

    // Randomized enable/stall/redirect traffic against the model.
    for (int i = 0; i < 400; i++) begin
      i_enable   = ($urandom_range(0, 9) != 0);
      i_stall    = ($urandom_range(0, 3) == 0);
      i_redirect = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) i_redirect_addr = AW'(32'h7FC + $urandom_range(0, 3));
      else i_redirect_addr = AW'($urandom);
      step(1);
    end
    i_stall = 1'b0;
    i_redirect = 1'b0;
    i_enable = 1'b1;
    step(4);

    // Asynchronous reset between edges clears outputs immediately.
    #1;
    i_rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(posedge i_clk);
    #2;
    i_rst = 1'b0;
    t4 = cyc;
    step(8);
    chk_seq("restart", t4 - 1, 0, t4 + 3, 4);

`ifdef FETCH_HALT_DETECT_EN
    // Halt word at address 5: delivered once, then fetch freezes.
    halt_at = 5;
    halt_cyc = -1;
    i_rst = 1'b1;
    step(2);
    i_rst = 1'b0;
    t5 = cyc;
    step(15);
    idx = first_after(t5 - 1);
    chk("halt_delivery_count", dlog.size() - idx, 6);
    if (idx >= 0 && dlog.size() - idx == 6) begin
      for (int k = 0; k < 6; k++) chk("halt_pc", dlog[idx+k].pc, k);
      chk("halt_word", dlog[idx+5].data, 32'h0005);
      chk("halt_deliver_cycle", dlog[idx+5].cyc, t5 + 8);
    end
    chk("halt_rise_cycle", halt_cyc, t5 + 9);
    chk("halt_flag", int'(o_halted), 1);
    chk("halt_valid", int'(o_inst_valid), 0);
    chk("halt_frozen_pc", int'(o_mem_addr), 8);
    i_redirect = 1'b1;
    i_redirect_addr = 11'h200;
    step(1);
    i_redirect = 1'b0;
    step(6);
    chk("halt_redirect_pc", int'(o_mem_addr), 8);
    chk("halt_redirect_flag", int'(o_halted), 1);
    chk("halt_redirect_deliveries", dlog.size() - idx, 6);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
